// File: rtl/run_length_detector_if.sv
// Sample/control and status bundle for run_length_detector.
// The master drives en/w/clr; the slave returns out, run_len and match_count.
interface run_length_detector_if #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned COUNT_W = 4
);
    localparam int unsigned RLW = $clog2(RUN_LEN + 1);

    logic               en;
    logic               w;
    logic               clr;
    logic               out;
    logic [RLW-1:0]     run_len;
    logic [COUNT_W-1:0] match_count;

    modport master (
        output en, w, clr,
        input  out, run_len, match_count
    );

    modport slave (
        input  en, w, clr,
        output out, run_len, match_count
    );
endinterface

// File: rtl/run_length_detector.sv
// Moore FSM that detects runs of RUN_LEN consecutive 1s on a serial input,
// with a level or one-shot output and a saturating count of detected runs.
module run_length_detector #(
    parameter int unsigned RUN_LEN = 3,
    parameter bit          PULSE   = 1'b0,
    parameter int unsigned COUNT_W = 4
) (
    input logic                  clk,
    input logic                  reset,
    run_length_detector_if.slave bus
);
    localparam int unsigned        RLW     = $clog2(RUN_LEN + 1);
    localparam logic [RLW-1:0]     RL_MAX  = RLW'(RUN_LEN);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDet} state_e;

    state_e             r_state, w_state_d;
    logic [RLW-1:0]     r_run_len, w_run_len_d;
    logic [COUNT_W-1:0] r_count, w_count_d;
    logic               r_out, w_out_d;
    logic               w_detect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_run_len <= '0;
            r_count   <= '0;
            r_out     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_run_len <= w_run_len_d;
            r_count   <= w_count_d;
            r_out     <= w_out_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_run_len_d = r_run_len;
        w_detect    = 1'b0;
        if (bus.en) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.w) begin
                        w_state_d   = StRun;
                        w_run_len_d = RLW'(1);
                    end
                end
                StRun: begin
                    if (bus.w) begin
                        w_run_len_d = r_run_len + 1'b1;
                        if (r_run_len == RL_MAX - 1'b1) begin
                            w_state_d = StDet;
                            w_detect  = 1'b1;
                        end
                    end else begin
                        w_state_d   = StIdle;
                        w_run_len_d = '0;
                    end
                end
                StDet: begin
                    if (!bus.w) begin
                        w_state_d   = StIdle;
                        w_run_len_d = '0;
                    end
                end
                default: begin
                    w_state_d   = StIdle;
                    w_run_len_d = '0;
                end
            endcase
        end
    end

    // out is registered from the next state so it tracks DET with no extra lag.
    always_comb begin
        w_out_d = PULSE ? w_detect : (w_state_d == StDet);
        if (bus.clr) begin
            w_count_d = '0;
        end else if (w_detect && (r_count != CNT_MAX)) begin
            w_count_d = r_count + 1'b1;
        end else begin
            w_count_d = r_count;
        end
    end

    assign bus.out         = r_out;
    assign bus.run_len     = r_run_len;
    assign bus.match_count = r_count;
endmodule

// File: tb/tb_run_length_detector.sv
// Drives a level-mode and a pulse-mode detector with identical stimulus and
// compares both against a run-counting reference model.
module tb_run_length_detector;
    localparam int unsigned RUN_LEN = 3;
    localparam int unsigned COUNT_W = 4;
    localparam int          CNT_SAT = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: unbounded count of consecutive enabled 1s.
    int   m_ones  = 0;
    int   m_cnt   = 0;
    logic m_pulse = 1'b0;

    always #5 clk = ~clk;

    run_length_detector_if #(.RUN_LEN(RUN_LEN), .COUNT_W(COUNT_W)) bus0 ();
    run_length_detector_if #(.RUN_LEN(RUN_LEN), .COUNT_W(COUNT_W)) bus1 ();

    run_length_detector #(.RUN_LEN(RUN_LEN), .PULSE(1'b0), .COUNT_W(COUNT_W)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    run_length_detector #(.RUN_LEN(RUN_LEN), .PULSE(1'b1), .COUNT_W(COUNT_W)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    logic [13:0] obs;
    assign obs = {bus0.run_len, bus0.out, bus0.match_count,
                  bus1.run_len, bus1.out, bus1.match_count};

    function automatic logic [13:0] expv();
        logic [1:0] rl;
        logic [3:0] c;
        rl = (m_ones >= int'(RUN_LEN)) ? 2'(RUN_LEN) : 2'(m_ones);
        c  = 4'(m_cnt);
        return {rl, logic'(m_ones >= int'(RUN_LEN)), c, rl, m_pulse, c};
    endfunction

    task automatic tick(input logic e, input logic wv, input logic c);
        bus0.en = e; bus0.w = wv; bus0.clr = c;
        bus1.en = e; bus1.w = wv; bus1.clr = c;
        m_pulse = e && wv && (m_ones == int'(RUN_LEN) - 1);
        if (c) m_cnt = 0;
        else if (m_pulse && m_cnt < CNT_SAT) m_cnt++;
        if (e) m_ones = wv ? m_ones + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus0.en = 1'b1; bus0.w = 1'b1; bus0.clr = 1'b0;
        bus1.en = 1'b1; bus1.w = 1'b1; bus1.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, 14'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs !== expv() || bus0.out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_long_run();
        logic [2:0] exp_rl [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (obs !== expv() || 3'(bus0.run_len) !== exp_rl[i] || bus0.out !== (i >= 2)) begin
                n_fail++;
                $display("FAIL long_run cyc %0d: got %h want %h", i, obs, expv());
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs !== expv() || bus0.out !== 1'b0 || bus0.match_count !== 4'd1) begin
            n_fail++;
            $display("FAIL long_run_end: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_partial();
        logic [6:0] pat = 7'b0111011; // applied LSB first: 1,1,0,1,1,1,0
        tick(1'b1, 1'b1, 1'b1);       // clear count so this scenario starts at 0
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, pat[i], 1'b0);
            n_tests++;
            if (obs !== expv() || (i == 2 && bus0.run_len !== 2'd0)) begin
                n_fail++;
                $display("FAIL partial cyc %0d: got %h want %h", i, obs, expv());
            end
        end
        n_tests++;
        if (bus0.match_count !== 4'd1) begin
            n_fail++;
            $display("FAIL partial_count: got %0d want 1", bus0.match_count);
        end
    endtask

    task automatic test_pulse();
        int pulses = 0;
        logic [12:0] pat = 13'b0011111011111; // 5 ones, 0, 5 ones, 0, 0 (LSB first)
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            tick(1'b1, pat[i], 1'b0);
            if (bus1.out === 1'b1) pulses++;
            n_tests++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL pulse cyc %0d: got %h want %h", i, obs, expv());
            end
        end
        n_tests++;
        if (pulses != 2 || bus1.match_count !== 4'd2) begin
            n_fail++;
            $display("FAIL pulse_total: got %0d pulses cnt %0d want 2 pulses cnt 2",
                     pulses, bus1.match_count);
        end
    endtask

    task automatic test_enable_hold();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, logic'(i[0]), 1'b0);
            n_tests++;
            if (obs !== expv() || bus0.run_len !== 2'd2) begin
                n_fail++;
                $display("FAIL en_hold cyc %0d: got %h want %h", i, obs, expv());
            end
        end
        tick(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs !== expv() || bus0.out !== 1'b1 || bus1.out !== 1'b1) begin
            n_fail++;
            $display("FAIL en_resume: got %h want %h", obs, expv());
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            n_tests++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL en_det_hold cyc %0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_saturation();
        tick(1'b1, 1'b0, 1'b1);
        for (int r = 0; r < 16; r++) begin
            repeat (3) tick(1'b1, 1'b1, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
        end
        n_tests++;
        if (obs !== expv() || bus0.match_count !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate: got %h want %h", obs, expv());
        end
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs !== expv() || bus0.match_count !== 4'd0 || bus0.out !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_detect: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_reset_in_det();
        tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        m_ones = 0; m_cnt = 0; m_pulse = 1'b0;
        n_tests++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_in_det: got %h want %h", obs, 14'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs !== expv() || bus0.run_len !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_restart: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 19) == 0));
            n_tests++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_long_run();
        test_partial();
        test_pulse();
        test_enable_hold();
        test_saturation();
        test_reset_in_det();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
